// File: rtl/instr_mem_loadable.sv
// Writable instruction memory with a handshaked program-load port and a
// registered, request-qualified fetch port that flags out-of-range addresses.
//
// Load handshake: a word is transferred on every rising edge where
// LoadReady=1 and LoadValid=1; LoadReady is high for the whole LOAD state
// and the sender may hold LoadValid low for any number of cycles.
module instr_mem_loadable #(
   parameter int DW    = 9,
   parameter int AW    = 12,
   parameter int DEPTH = 2**AW
) (
   input  logic          Clk,
   input  logic          Reset_n,
   input  logic          LoadStart,
   input  logic [AW:0]   LoadLen,
   input  logic [DW-1:0] LoadData,
   input  logic          LoadValid,
   output logic          LoadReady,
   output logic          LoadDone,
   output logic          ProgReady,
   input  logic          FetchReq,
   input  logic [AW-1:0] FetchAddr,
   output logic [DW-1:0] InstrOut,
   output logic          InstrValid,
   output logic          AddrErr,
   output logic [1:0]    DbgState
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2
   } state_t;

   localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];
   localparam logic [AW:0] ONE_W   = {{AW{1'b0}}, 1'b1};

   state_t        state_q;
   logic [AW-1:0] wptr_q;
   logic [AW:0]   len_q;
   logic [AW:0]   len_d;
   logic          load_ready_q;
   logic          load_done_q;
   logic          prog_ready_q;

   logic [DW-1:0] instr_q;
   logic          instr_valid_q;
   logic          addr_err_q;

   logic [DW-1:0] mem_q [0:DEPTH-1];

   logic          beat;
   logic          last_beat;
   logic          fetch_ok;
   logic          in_range;
   logic [AW-1:0] rd_idx;

   always_comb begin
      len_d     = (LoadLen > DEPTH_W) ? DEPTH_W : LoadLen;
      beat      = (state_q == S_LOAD) && LoadValid;
      last_beat = beat && ({1'b0, wptr_q} == (len_q - ONE_W));
      // A load request in RUN takes priority over a same-cycle fetch.
      fetch_ok  = (state_q == S_RUN) && FetchReq && !LoadStart;
      in_range  = ({1'b0, FetchAddr} < DEPTH_W);
      rd_idx    = in_range ? FetchAddr : '0;
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q      <= S_IDLE;
         wptr_q       <= '0;
         len_q        <= '0;
         load_ready_q <= 1'b0;
         load_done_q  <= 1'b0;
         prog_ready_q <= 1'b0;
      end else begin
         load_done_q <= 1'b0;
         case (state_q)
            S_IDLE, S_RUN: begin
               if (LoadStart) begin
                  len_q  <= len_d;
                  wptr_q <= '0;
                  if (len_d == '0) begin
                     state_q      <= S_RUN;
                     load_done_q  <= 1'b1;
                     load_ready_q <= 1'b0;
                     prog_ready_q <= 1'b1;
                  end else begin
                     state_q      <= S_LOAD;
                     load_ready_q <= 1'b1;
                     prog_ready_q <= 1'b0;
                  end
               end
            end
            S_LOAD: begin
               if (last_beat) begin
                  state_q      <= S_RUN;
                  wptr_q       <= '0;
                  load_done_q  <= 1'b1;
                  load_ready_q <= 1'b0;
                  prog_ready_q <= 1'b1;
               end else if (beat) begin
                  wptr_q <= wptr_q + 1'b1;
               end
            end
            default: begin
               state_q      <= S_IDLE;
               load_ready_q <= 1'b0;
               prog_ready_q <= 1'b0;
            end
         endcase
      end
   end

   // Storage is deliberately not reset so a partial program survives reset.
   always_ff @(posedge Clk) begin
      if (beat) begin
         mem_q[wptr_q] <= LoadData;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         instr_q       <= '0;
         instr_valid_q <= 1'b0;
         addr_err_q    <= 1'b0;
      end else begin
         instr_valid_q <= fetch_ok;
         addr_err_q    <= fetch_ok && !in_range;
         if (fetch_ok) begin
            instr_q <= in_range ? mem_q[rd_idx] : '0;
         end
      end
   end

   assign LoadReady  = load_ready_q;
   assign LoadDone   = load_done_q;
   assign ProgReady  = prog_ready_q;
   assign InstrOut   = instr_q;
   assign InstrValid = instr_valid_q;
   assign AddrErr    = addr_err_q;
   assign DbgState   = state_q;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Bench for instr_mem_loadable: a 3000-word instance for the main scenarios
// and a 4-word instance for load-length saturation, checked against an array model.
module tb_instr_mem_loadable;

   localparam int DW      = 9;
   localparam int AW      = 12;
   localparam int DEPTH   = 3000;
   localparam int B_AW    = 3;
   localparam int B_DEPTH = 4;

   logic Clk = 1'b0;
   logic Reset_n = 1'b0;

   logic          a_start, a_valid, a_req;
   logic [AW:0]   a_len;
   logic [DW-1:0] a_data;
   logic [AW-1:0] a_addr;
   logic          a_ready, a_done, a_prog, a_ivalid, a_err;
   logic [DW-1:0] a_instr;
   logic [1:0]    a_dbg;

   logic          b_start, b_valid, b_req;
   logic [B_AW:0] b_len;
   logic [DW-1:0] b_data;
   logic [B_AW-1:0] b_addr;
   logic          b_ready, b_done, b_prog, b_ivalid, b_err;
   logic [DW-1:0] b_instr;
   logic [1:0]    b_dbg;

   int n_checks = 0;
   int n_fail   = 0;

   logic [DW-1:0] ref_mem [0:DEPTH-1];
   logic [DW-1:0] load_buf [0:63];
   logic [DW-1:0] exp_q [$];
   logic [DW-1:0] exp_last;

   instr_mem_loadable #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut_a (
      .Clk(Clk), .Reset_n(Reset_n),
      .LoadStart(a_start), .LoadLen(a_len), .LoadData(a_data), .LoadValid(a_valid),
      .LoadReady(a_ready), .LoadDone(a_done), .ProgReady(a_prog),
      .FetchReq(a_req), .FetchAddr(a_addr),
      .InstrOut(a_instr), .InstrValid(a_ivalid), .AddrErr(a_err), .DbgState(a_dbg)
   );

   instr_mem_loadable #(.DW(DW), .AW(B_AW), .DEPTH(B_DEPTH)) dut_b (
      .Clk(Clk), .Reset_n(Reset_n),
      .LoadStart(b_start), .LoadLen(b_len), .LoadData(b_data), .LoadValid(b_valid),
      .LoadReady(b_ready), .LoadDone(b_done), .ProgReady(b_prog),
      .FetchReq(b_req), .FetchAddr(b_addr),
      .InstrOut(b_instr), .InstrValid(b_ivalid), .AddrErr(b_err), .DbgState(b_dbg)
   );

   always #5 Clk = ~Clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic idle_inputs();
      a_start = 0; a_valid = 0; a_req = 0; a_len = '0; a_data = '0; a_addr = '0;
      b_start = 0; b_valid = 0; b_req = 0; b_len = '0; b_data = '0; b_addr = '0;
   endtask

   // Loads load_buf[0..len-1] into dut_a with random LoadValid stalls.
   task automatic load_a(input int len, input int stall_pct);
      int eff;
      int beats;
      int cycles;
      eff = (len > DEPTH) ? DEPTH : len;
      a_start = 1; a_len = len[AW:0];
      step();
      a_start = 0;
      n_checks++;
      if (len == 0) begin
         if (a_done !== 1'b1 || a_prog !== 1'b1) begin
            n_fail++; $display("FAIL load0_done: done=%b prog=%b, want 1 1", a_done, a_prog);
         end
         step();
         n_checks++;
         if (a_done !== 1'b0) begin
            n_fail++; $display("FAIL load0_pulse: done=%b, want 0", a_done);
         end
         return;
      end
      if (a_ready !== 1'b1 || a_prog !== 1'b0) begin
         n_fail++; $display("FAIL load_enter: ready=%b prog=%b, want 1 0", a_ready, a_prog);
      end
      beats = 0;
      cycles = 0;
      while (beats < eff) begin
         if (beats > 0 && $urandom_range(0, 99) < stall_pct) begin
            a_valid = 0; a_data = DW'($urandom);
         end else begin
            a_valid = 1; a_data = load_buf[beats];
         end
         step();
         cycles++;
         if (a_valid) begin
            ref_mem[beats] = load_buf[beats];
            beats++;
         end
         if (beats < eff) begin
            n_checks++;
            if (a_done !== 1'b0 || a_ready !== 1'b1) begin
               n_fail++; $display("FAIL load_mid: beat=%0d done=%b ready=%b, want 0 1", beats, a_done, a_ready);
            end
         end
         if (cycles > 2000) begin
            n_checks++; n_fail++;
            $display("FAIL load_timeout: beats=%0d of %0d", beats, eff);
            break;
         end
      end
      a_valid = 0;
      n_checks++;
      if (a_done !== 1'b1 || a_prog !== 1'b1 || a_ready !== 1'b0) begin
         n_fail++; $display("FAIL load_end: done=%b prog=%b ready=%b, want 1 1 0", a_done, a_prog, a_ready);
      end
      step();
      n_checks++;
      if (a_done !== 1'b0 || a_prog !== 1'b1) begin
         n_fail++; $display("FAIL load_pulse: done=%b prog=%b, want 0 1", a_done, a_prog);
      end
   endtask

   // Issues one fetch on dut_a; leaves FetchReq asserted so calls chain back-to-back.
   task automatic fetch_a(input int addr);
      logic [DW-1:0] want;
      logic          want_err;
      a_req = 1; a_addr = addr[AW-1:0];
      step();
      want_err = (addr >= DEPTH);
      want = want_err ? '0 : ref_mem[addr];
      n_checks++;
      if (a_ivalid !== 1'b1 || a_err !== want_err || a_instr !== want) begin
         n_fail++;
         $display("FAIL fetch_a: addr=%0d valid=%b err=%b instr=%h, want 1 %b %h",
                  addr, a_ivalid, a_err, a_instr, want_err, want);
      end
      exp_last = want;
   endtask

   task automatic test_reset();
      idle_inputs();
      Reset_n = 0;
      repeat (2) step();
      n_checks++;
      if (a_ready !== 0 || a_done !== 0 || a_prog !== 0 || a_ivalid !== 0 || a_err !== 0 || a_instr !== '0) begin
         n_fail++;
         $display("FAIL reset_vals: ready=%b done=%b prog=%b valid=%b err=%b instr=%h, want all 0",
                  a_ready, a_done, a_prog, a_ivalid, a_err, a_instr);
      end
      Reset_n = 1;
      exp_last = '0;
      a_req = 1; a_addr = '0;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++;
         if (a_ivalid !== 0 || a_prog !== 0 || a_err !== 0 || a_instr !== '0) begin
            n_fail++;
            $display("FAIL idle_fetch: cyc=%0d valid=%b prog=%b err=%b instr=%h, want 0 0 0 0",
                     i, a_ivalid, a_prog, a_err, a_instr);
         end
      end
      a_req = 0;
   endtask

   task automatic test_load4();
      load_buf[0] = 9'h1A1; load_buf[1] = 9'h0F2; load_buf[2] = 9'h155; load_buf[3] = 9'h003;
      load_a(4, 0);
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] want;
      exp_q.push_back(9'h003); exp_q.push_back(9'h155);
      exp_q.push_back(9'h0F2); exp_q.push_back(9'h1A1);
      for (int addr = 3; addr >= 0; addr--) begin
         a_req = 1; a_addr = addr[AW-1:0];
         step();
         want = exp_q.pop_front();
         n_checks++;
         if (a_ivalid !== 1'b1 || a_err !== 1'b0 || a_instr !== want) begin
            n_fail++;
            $display("FAIL b2b_fetch: addr=%0d valid=%b err=%b instr=%h, want 1 0 %h",
                     addr, a_ivalid, a_err, a_instr, want);
         end
         exp_last = want;
      end
      a_req = 0;
      step();
      n_checks++;
      if (a_ivalid !== 1'b0 || a_err !== 1'b0 || a_instr !== exp_last) begin
         n_fail++;
         $display("FAIL hold_instr: valid=%b err=%b instr=%h, want 0 0 %h", a_ivalid, a_err, a_instr, exp_last);
      end
   endtask

   task automatic test_reload();
      load_buf[0] = 9'h1FF;
      load_a(1, 0);
      fetch_a(0);
      n_checks++;
      if (a_instr !== 9'h1FF) begin
         n_fail++; $display("FAIL reload_w0: instr=%h, want 1ff", a_instr);
      end
      fetch_a(1);
      n_checks++;
      if (a_instr !== 9'h0F2) begin
         n_fail++; $display("FAIL reload_w1: instr=%h, want 0f2", a_instr);
      end
      a_req = 0;
      step();
   endtask

   task automatic test_valid_gaps();
      bit            pat [0:4];
      logic [DW-1:0] words [0:2];
      int            k;
      pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1; pat[4] = 1;
      words[0] = 9'h0AA; words[1] = 9'h0BB; words[2] = 9'h0CC;
      a_start = 1; a_len = 13'd3;
      step();
      a_start = 0;
      k = 0;
      for (int i = 0; i < 5; i++) begin
         a_valid = pat[i];
         a_data  = pat[i] ? words[k] : 9'h1EE;
         // A start request during LOAD must be ignored.
         if (i == 1) begin a_start = 1; a_len = '0; end
         step();
         a_start = 0;
         if (pat[i]) begin ref_mem[k] = words[k]; k++; end
         n_checks++;
         if (a_done !== (i == 4) || a_ready !== (i != 4)) begin
            n_fail++;
            $display("FAIL gap_load: cyc=%0d done=%b ready=%b, want %b %b", i, a_done, a_ready, i == 4, i != 4);
         end
      end
      a_valid = 0;
      for (int addr = 0; addr < 4; addr++) fetch_a(addr);
      a_req = 0;
      step();
   endtask

   task automatic test_addr_range();
      a_req = 1; a_addr = 12'd2999;
      step();
      n_checks++;
      if (a_ivalid !== 1'b1 || a_err !== 1'b0) begin
         n_fail++; $display("FAIL range_2999: valid=%b err=%b, want 1 0", a_ivalid, a_err);
      end
      fetch_a(3000);
      fetch_a(4095);
      fetch_a(2);
      a_req = 0;
      step();
   endtask

   task automatic test_load_wins();
      a_req = 1; a_addr = '0; a_start = 1; a_len = '0;
      step();
      a_req = 0; a_start = 0;
      n_checks++;
      if (a_ivalid !== 1'b0 || a_done !== 1'b1 || a_prog !== 1'b1 || a_instr !== exp_last) begin
         n_fail++;
         $display("FAIL load_wins: valid=%b done=%b prog=%b instr=%h, want 0 1 1 %h",
                  a_ivalid, a_done, a_prog, a_instr, exp_last);
      end
      step();
   endtask

   task automatic test_saturation();
      b_start = 1; b_len = 4'd8;
      step();
      b_start = 0;
      for (int i = 0; i < 4; i++) begin
         b_valid = 1; b_data = 9'h100 + 9'(i * 7);
         step();
         n_checks++;
         if (b_done !== (i == 3) || b_ready !== (i != 3) || b_prog !== (i == 3)) begin
            n_fail++;
            $display("FAIL sat_load: beat=%0d done=%b ready=%b prog=%b, want %b %b %b",
                     i, b_done, b_ready, b_prog, i == 3, i != 3, i == 3);
         end
      end
      b_valid = 0;
      for (int i = 0; i < 5; i++) begin
         b_req = 1; b_addr = i[B_AW-1:0];
         step();
         n_checks++;
         if (i < 4) begin
            if (b_ivalid !== 1'b1 || b_err !== 1'b0 || b_instr !== 9'h100 + 9'(i * 7)) begin
               n_fail++;
               $display("FAIL sat_fetch: addr=%0d valid=%b err=%b instr=%h, want 1 0 %h",
                        i, b_ivalid, b_err, b_instr, 9'h100 + 9'(i * 7));
            end
         end else if (b_ivalid !== 1'b1 || b_err !== 1'b1 || b_instr !== '0) begin
            n_fail++;
            $display("FAIL sat_range: valid=%b err=%b instr=%h, want 1 1 000", b_ivalid, b_err, b_instr);
         end
      end
      b_req = 0;
      step();
   endtask

   task automatic test_reset_midload();
      a_start = 1; a_len = 13'd4;
      step();
      a_start = 0;
      for (int i = 0; i < 2; i++) begin
         a_valid = 1; a_data = 9'h011 * 9'(i + 1);
         step();
         ref_mem[i] = 9'h011 * 9'(i + 1);
      end
      a_valid = 0;
      #2;
      Reset_n = 0;
      #1;
      n_checks++;
      if (a_prog !== 0 || a_ready !== 0 || a_done !== 0 || a_ivalid !== 0 || a_instr !== '0) begin
         n_fail++;
         $display("FAIL midload_reset: prog=%b ready=%b done=%b valid=%b instr=%h, want all 0",
                  a_prog, a_ready, a_done, a_ivalid, a_instr);
      end
      exp_last = '0;
      step();
      Reset_n = 1;
      step();
      load_a(0, 0);
      fetch_a(0);
      fetch_a(1);
      fetch_a(2);
      a_req = 0;
      step();
   endtask

   task automatic test_random();
      int len;
      int addr;
      for (int r = 0; r < 4; r++) begin
         len = $urandom_range(1, 48);
         for (int i = 0; i < len; i++) load_buf[i] = DW'($urandom);
         load_a(len, 30);
         for (int op = 0; op < 24; op++) begin
            if ($urandom_range(0, 99) < 20) begin
               a_req = 0; a_addr = AW'($urandom);
               step();
               n_checks++;
               if (a_ivalid !== 1'b0 || a_err !== 1'b0 || a_instr !== exp_last) begin
                  n_fail++;
                  $display("FAIL rand_idle: valid=%b err=%b instr=%h, want 0 0 %h", a_ivalid, a_err, a_instr, exp_last);
               end
            end else begin
               if ($urandom_range(0, 99) < 20) addr = $urandom_range(DEPTH, 4095);
               else addr = $urandom_range(0, len - 1);
               fetch_a(addr);
            end
         end
         a_req = 0;
         step();
      end
   endtask

   initial begin
      test_reset();
      test_load4();
      test_back_to_back();
      test_reload();
      test_valid_gaps();
      test_addr_range();
      test_load_wins();
      test_saturation();
      test_reset_midload();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
